// File: rtl/sp_stream_reader_if.sv
// Handshake bundle between the scratchpad stream reader and its environment:
// start command, status, scratchpad element-read port and the element stream.
interface sp_stream_reader_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W   = $clog2(MAX_DIM) + 1;
  localparam int IDX_W   = $clog2(MAX_DIM);
  localparam int SUB_W   = 2 * IDX_W;

  logic                 start_i;
  logic [1:0]           target_i;
  logic [DIM_W-1:0]     n_rows_i;
  logic [DIM_W-1:0]     n_cols_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [1:0]           sp_address_o;
  logic [SUB_W-1:0]     sp_sub_address_o;
  logic [BUS_WIDTH-1:0] sp_data_i;
  logic [BUS_WIDTH-1:0] elem_o;
  logic                 elem_valid_o;
  logic                 elem_ready_i;
  logic                 elem_last_o;
  logic [IDX_W-1:0]     elem_row_o;
  logic [IDX_W-1:0]     elem_col_o;

  modport master (
    input  start_i, target_i, n_rows_i, n_cols_i, sp_data_i, elem_ready_i,
    output busy_o, done_o, err_o, sp_address_o, sp_sub_address_o,
           elem_o, elem_valid_o, elem_last_o, elem_row_o, elem_col_o
  );

  modport slave (
    output start_i, target_i, n_rows_i, n_cols_i, sp_data_i, elem_ready_i,
    input  busy_o, done_o, err_o, sp_address_o, sp_sub_address_o,
           elem_o, elem_valid_o, elem_last_o, elem_row_o, elem_col_o
  );
endinterface

// File: rtl/sp_stream_reader.sv
// Read-side master for the matrix scratchpad: walks a rows x cols sub-matrix
// of one target in row-major order and streams each element with row/col tags.
module sp_stream_reader #(
  parameter int BUS_WIDTH   = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SP_NTARGETS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sp_stream_reader_if.master  bus
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W   = $clog2(MAX_DIM) + 1;
  localparam int IDX_W   = $clog2(MAX_DIM);
  localparam int SUB_W   = 2 * IDX_W;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           tgt_q;
  logic [DIM_W-1:0]     rows_q, cols_q;
  logic [IDX_W-1:0]     r_q, c_q;
  logic [IDX_W-1:0]     r_nx, c_nx;
  logic [SUB_W-1:0]     sub_nx;
  logic                 cmd_ok;
  logic                 handshake;
  logic                 c_wrap;
  logic                 is_last;

  logic [BUS_WIDTH-1:0] elem_q;
  logic                 valid_q, last_q, err_q;
  logic [IDX_W-1:0]     row_q, col_q;
  logic [1:0]           sp_addr_q;
  logic [SUB_W-1:0]     sp_sub_q;

  // Command legality, handshake and next element position.
  always_comb begin
    cmd_ok    = (int'(bus.target_i) < SP_NTARGETS) &&
                (bus.n_rows_i != '0) && (int'(bus.n_rows_i) <= MAX_DIM) &&
                (bus.n_cols_i != '0) && (int'(bus.n_cols_i) <= MAX_DIM);
    handshake = valid_q && bus.elem_ready_i;
    c_wrap    = (DIM_W'(c_q) == cols_q - DIM_W'(1));
    is_last   = (DIM_W'(r_q) == rows_q - DIM_W'(1)) && c_wrap;
    c_nx      = c_wrap ? '0 : c_q + IDX_W'(1);
    r_nx      = c_wrap ? r_q + IDX_W'(1) : r_q;
    sub_nx    = SUB_W'(r_nx) * SUB_W'(MAX_DIM) + SUB_W'(c_nx);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_d     = state_q;
    bus.busy_o  = (state_q != IDLE);
    bus.done_o  = (state_q == DONE);
    unique case (state_q)
      IDLE:    if (bus.start_i && cmd_ok) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (handshake) state_d = last_q ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, position counters, element capture and read-port address.
  // The read-port address is loaded on the edge that enters FETCH so that it
  // is valid throughout FETCH and simply holds outside it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tgt_q     <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      r_q       <= '0;
      c_q       <= '0;
      elem_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
      sp_addr_q <= '0;
      sp_sub_q  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (cmd_ok) begin
              tgt_q     <= bus.target_i;
              rows_q    <= bus.n_rows_i;
              cols_q    <= bus.n_cols_i;
              r_q       <= '0;
              c_q       <= '0;
              sp_addr_q <= bus.target_i;
              sp_sub_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          elem_q  <= bus.sp_data_i;
          row_q   <= r_q;
          col_q   <= c_q;
          last_q  <= is_last;
          valid_q <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (!last_q) begin
              r_q       <= r_nx;
              c_q       <= c_nx;
              sp_addr_q <= tgt_q;
              sp_sub_q  <= sub_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.err_o            = err_q;
  assign bus.sp_address_o     = sp_addr_q;
  assign bus.sp_sub_address_o = sp_sub_q;
  assign bus.elem_o           = elem_q;
  assign bus.elem_valid_o     = valid_q;
  assign bus.elem_last_o      = last_q;
  assign bus.elem_row_o       = row_q;
  assign bus.elem_col_o       = col_q;
endmodule

// File: tb/tb_sp_stream_reader.sv
// Bench for sp_stream_reader: directed scenarios plus randomized commands,
// checked against a row-major reference walk over a scratchpad array.
module tb_sp_stream_reader;
  localparam int BUS_WIDTH   = 16;
  localparam int DATA_WIDTH  = 8;
  localparam int SP_NTARGETS = 2;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
    bit          last;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   last_t   = 0;
  int   last_sub = 0;
  logic [15:0] mem [4][4];

  sp_stream_reader_if #(.BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  sp_stream_reader #(
    .BUS_WIDTH  (BUS_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SP_NTARGETS(SP_NTARGETS)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  assign bus.sp_data_i = mem[bus.sp_address_o][bus.sp_sub_address_o];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one legal command and checks the stream against a row-major model.
  task automatic run_cmd(input int t, input int rows, input int cols,
                         input int stall, input bit snap, input bit poke,
                         input bit rnd_ready);
    exp_t q[$];
    exp_t e;
    int   busy_cnt = 0;
    int   guard = 0;
    int   stall_left = stall;
    bit   got_done = 0;
    bit   err_seen = 0;
    bit   busy_lost = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        e.d = mem[t][r*MAX_DIM+c];
        e.r = r;
        e.c = c;
        e.last = (r == rows-1) && (c == cols-1);
        q.push_back(e);
      end
    bus.start_i  = 1'b1;
    bus.target_i = 2'(t);
    bus.n_rows_i = 2'(rows);
    bus.n_cols_i = 2'(cols);
    tick();
    bus.start_i = 1'b0;
    while (!got_done && guard < 200) begin
      guard++;
      if (bus.err_o) err_seen = 1;
      if (bus.done_o) begin
        got_done = 1;
        chk("queue_empty", q.size(), 0);
        chk("done_busy", 32'(bus.busy_o), 1);
      end else begin
        busy_cnt++;
        if (!bus.busy_o) busy_lost = 1;
        if (!bus.elem_valid_o) begin
          if (stall_left > 0 && stall_left < stall) chk("stall_valid", 0, 1);
          if (q.size() > 0) begin
            chk("sp_addr", 32'(bus.sp_address_o), t);
            chk("sp_sub", 32'(bus.sp_sub_address_o), q[0].r*MAX_DIM + q[0].c);
          end
          bus.elem_ready_i = 1'b1;
        end else if (q.size() == 0) begin
          chk("extra_elem", 1, 0);
          bus.elem_ready_i = 1'b1;
        end else begin
          chk("elem", 32'(bus.elem_o), 32'(q[0].d));
          chk("row", 32'(bus.elem_row_o), q[0].r);
          chk("col", 32'(bus.elem_col_o), q[0].c);
          chk("last", 32'(bus.elem_last_o), 32'(q[0].last));
          if (stall_left > 0) begin
            bus.elem_ready_i = 1'b0;
            stall_left--;
            if (snap && stall_left == 2) mem[t][0] = 16'hAAAA;
          end else begin
            bus.elem_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (bus.elem_ready_i) void'(q.pop_front());
        end
        if (poke && guard == 2) begin
          bus.start_i  = 1'b1;
          bus.target_i = 2'd2;
          bus.n_rows_i = 2'd0;
        end else begin
          bus.start_i = 1'b0;
        end
        tick();
      end
    end
    bus.start_i = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("busy_held", 32'(busy_lost), 0);
    chk("no_err_while_busy", 32'(err_seen), 0);
    if (!rnd_ready && stall == 0) chk("busy_cycles", busy_cnt, 2*rows*cols);
    tick();
    chk("done_pulse", 32'(bus.done_o), 0);
    chk("idle_busy", 32'(bus.busy_o), 0);
    last_t   = t;
    last_sub = (rows-1)*MAX_DIM + (cols-1);
  endtask

  // Issues a start that must be rejected and leave everything else alone.
  task automatic illegal(input int t, input int rows, input int cols);
    bus.start_i  = 1'b1;
    bus.target_i = 2'(t);
    bus.n_rows_i = 2'(rows);
    bus.n_cols_i = 2'(cols);
    tick();
    bus.start_i = 1'b0;
    chk("err_pulse", 32'(bus.err_o), 1);
    chk("err_busy", 32'(bus.busy_o), 0);
    chk("err_valid", 32'(bus.elem_valid_o), 0);
    chk("err_sp_addr", 32'(bus.sp_address_o), last_t);
    chk("err_sp_sub", 32'(bus.sp_sub_address_o), last_sub);
    tick();
    chk("err_clear", 32'(bus.err_o), 0);
    chk("err_still_idle", 32'(bus.busy_o), 0);
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.target_i     = '0;
    bus.n_rows_i     = '0;
    bus.n_cols_i     = '0;
    bus.elem_ready_i = 1'b1;
    for (int a = 0; a < 4; a++)
      for (int s = 0; s < 4; s++) mem[a][s] = '0;
    mem[1][0] = 16'h1111;
    mem[1][1] = 16'h2222;
    mem[1][2] = 16'h3333;
    mem[1][3] = 16'h4444;

    tick();
    tick();
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_valid", 32'(bus.elem_valid_o), 0);
    chk("rst_elem", 32'(bus.elem_o), 0);
    chk("rst_last", 32'(bus.elem_last_o), 0);
    chk("rst_sp_addr", 32'(bus.sp_address_o), 0);
    chk("rst_sp_sub", 32'(bus.sp_sub_address_o), 0);
    rst_i = 1'b0;
    tick();

    run_cmd(1, 2, 2, 0, 0, 0, 0);
    run_cmd(1, 2, 1, 0, 0, 0, 0);
    run_cmd(1, 2, 2, 5, 1, 0, 0);
    mem[1][0] = 16'h1111;

    illegal(1, 3, 1);
    illegal(1, 1, 0);
    illegal(2, 1, 1);

    run_cmd(1, 2, 2, 0, 0, 1, 0);

    // Reset during the second SEND: E0 -> FETCH, SEND, FETCH, SEND.
    bus.elem_ready_i = 1'b1;
    bus.start_i  = 1'b1;
    bus.target_i = 2'd1;
    bus.n_rows_i = 2'd2;
    bus.n_cols_i = 2'd2;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_valid", 32'(bus.elem_valid_o), 1);
    chk("pre_rst_elem", 32'(bus.elem_o), 32'h2222);
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.elem_valid_o), 0);
    chk("async_rst_busy", 32'(bus.busy_o), 0);
    chk("async_rst_done", 32'(bus.done_o), 0);
    tick();
    rst_i = 1'b0;
    last_t = 0;
    last_sub = 0;
    tick();
    chk("post_rst_done", 32'(bus.done_o), 0);
    mem[0][0] = 16'h5555;
    run_cmd(0, 1, 1, 0, 0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      int t = $urandom_range(0, SP_NTARGETS-1);
      for (int s = 0; s < 4; s++) mem[t][s] = 16'($urandom);
      run_cmd(t, $urandom_range(1, MAX_DIM), $urandom_range(1, MAX_DIM),
              0, 0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sp_stream_reader.md
Name: sp_stream_reader

Overview:
- Read-side master for the matrix scratchpad.
- On a start command it walks a rows x cols sub-matrix of one scratchpad target in row-major order, driving the scratchpad element-read port (target address, flat sub-address) and capturing the combinational read data.
- Each captured element goes out on a valid/ready stream with row/col tags and a last flag.
- Feeds serial consumers such as the bus read-back path and the result drain.

Parameters:
BUS_WIDTH, 16, width of one scratchpad element / stream word
DATA_WIDTH, 8, operand width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
SP_NTARGETS, 2, number of scratchpad matrices; legal target range 0..SP_NTARGETS-1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  start command; sampled only in IDLE
target_i  in  2  scratchpad target to read
n_rows_i  in  $clog2(MAX_DIM)+1  rows to read, legal 1..MAX_DIM
n_cols_i  in  $clog2(MAX_DIM)+1  cols to read, legal 1..MAX_DIM
busy_o  out  1  high while not IDLE
done_o  out  1  one-cycle pulse after last handshake
err_o  out  1  one-cycle pulse on rejected start
sp_address_o  out  2  to scratchpad address_i
sp_sub_address_o  out  2*$clog2(MAX_DIM)  to scratchpad sub_address_i, flat index r*MAX_DIM+c
sp_data_i  in  BUS_WIDTH  from scratchpad Data_o (combinational read)
elem_o  out  BUS_WIDTH  stream data (registered)
elem_valid_o  out  1  stream valid
elem_ready_i  in  1  stream ready
elem_last_o  out  1  marks final element of the command
elem_row_o  out  $clog2(MAX_DIM)  row of elem_o
elem_col_o  out  $clog2(MAX_DIM)  col of elem_o

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-command. State goes to IDLE; all outputs, counters and latched command are 0. The in-flight command is abandoned and done_o is not pulsed.
- States: IDLE, FETCH, SEND, DONE.
- IDLE, start_i high at edge E0:
  - If target_i >= SP_NTARGETS, n_rows_i or n_cols_i is 0, or either exceeds MAX_DIM: err_o is high for the one cycle after E0 and the state stays IDLE.
  - Otherwise latch target, rows and cols; set r=c=0; go to FETCH.
- FETCH (exactly one cycle):
  - sp_address_o = latched target; sp_sub_address_o = r*MAX_DIM+c.
  - At the closing edge: elem_o <= sp_data_i, tags <= r/c, elem_last_o <= (r==rows-1 && c==cols-1), elem_valid_o <= 1; go to SEND.
- SEND:
  - elem_o, tags and last are held stable while valid && !ready.
  - A handshake (valid && ready at an edge) clears valid.
  - If last: go to DONE. Else advance c, wrapping to 0 with r+1 at c==cols-1, and go to FETCH.
- DONE (one cycle): done_o=1, busy_o=1. Next state IDLE.
- Throughput is one element per 2 cycles at full ready. The first valid appears after edge E1 (one FETCH cycle after start).
- Data is a snapshot taken at the FETCH edge. Later scratchpad writes do not alter a word already held in elem_o.
- sp_address_o and sp_sub_address_o hold their last value outside FETCH; they are 0 after reset.
- start_i is ignored while busy (no err_o).
- Counters use exactly the stated widths; no element outside rows x cols is ever addressed.

Test Plan:
- Preload target1 = {0x1111,0x2222,0x3333,0x4444} (flat 0..3). Start target=1, 2x2, ready held 1 -> elem_o 0x1111,0x2222,0x3333,0x4444 with (r,c) = (0,0),(0,1),(1,0),(1,1); last only on 0x4444; done_o one cycle; 8 busy cycles after start.
- Start target=1, 2 rows x 1 col -> 0x1111 then 0x3333 (sub-addresses 0, 2); last on 0x3333.
- Backpressure: 2x2 with ready low for 5 cycles on the first element -> elem_o stays 0x1111 and valid stays high throughout; the sequence then continues unchanged.
- Illegal starts: n_rows=3, then n_cols=0, then target=2 -> err_o pulses each time; valid, busy and sp_* unchanged. A second start_i while busy -> ignored, no err_o.
- Snapshot: a scratchpad write of 0xAAAA to flat 0 while element 0 is in SEND with ready low -> the stream still delivers 0x1111.
- Reset mid-command: assert rst_i during the second SEND -> valid, busy and done go 0 immediately. A new 1x1 start on target0 (flat0=0x5555) -> single element 0x5555 with last=1.
